// File: rtl/ascon_serial_ctrl.sv
// Job sequencer for the bit-serial Ascon core: parallel capture, serial load
// with fresh masking randomness, start/ready handshakes with timeout, and
// serial-to-parallel readout of ciphertext, tags, plaintext and auth result.
module ascon_serial_ctrl #(
  parameter int K         = 128,
  parameter int L         = 40,
  parameter int Y         = 40,
  parameter int START_CYC = 5,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  input  logic                        cmd_dec,
  input  logic [K-1:0]                key_in,
  input  logic [127:0]                nonce_in,
  input  logic [((L > 0) ? L : 1)-1:0] ad_in,
  input  logic [((Y > 0) ? Y : 1)-1:0] pt_in,
  input  logic [20:0]                 rnd_in,
  output logic [2:0]                  keyxSO,
  output logic [2:0]                  noncexSO,
  output logic [2:0]                  associated_dataxSO,
  output logic [2:0]                  plain_textxSO,
  output logic [6:0]                  r_64xSO,
  output logic [2:0]                  r_128xSO,
  output logic [2:0]                  r_ptxSO,
  output logic                        enc_startxSO,
  output logic                        dec_startxSO,
  input  logic                        cipher_textxSI,
  input  logic                        tagxSI,
  input  logic                        plain_textxSI,
  input  logic                        dec_tagxSI,
  input  logic                        enc_readyxSI,
  input  logic                        dec_readyxSI,
  input  logic                        auth_xSI,
  output logic [((Y > 0) ? Y : 1)-1:0] ct_out,
  output logic [127:0]                tag_out,
  output logic [((Y > 0) ? Y : 1)-1:0] pt_out,
  output logic [127:0]                dec_tag_out,
  output logic                        auth_ok,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int LW   = (L > 0) ? L : 1;
  localparam int YW   = (Y > 0) ? Y : 1;
  localparam int MAX1 = (K > TIMEOUT) ? K : TIMEOUT;
  localparam int CMAX = (MAX1 > START_CYC + GAP_CYC) ? MAX1 : START_CYC + GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] K_LAST     = CW'(K - 1);
  localparam logic [CW-1:0] START_LEN  = CW'(START_CYC);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT_ENC, GAP_ENC, READ_ENC, WAIT_DEC, GAP_DEC, READ_DEC, DONE
  } stateT;

  stateT          state, nextState;
  logic [CW-1:0]  cnt;
  logic           readySeen;
  logic           timeoutHit;
  logic           decMode;
  logic           doneR;
  logic           timeoutErr;
  logic [K-1:0]   keySh;
  logic [127:0]   nonceSh;
  logic [LW-1:0]  adSh;
  logic [YW-1:0]  ptSh;
  logic [YW-1:0]  ctR, ptR;
  logic [127:0]   tagR, decTagR;
  logic           authR;
  logic           encReady;
  logic           adBit, ptBit;

  // Job fields are consumed MSB first by shifting; zeros fill in behind, so
  // a field shorter than K naturally reads as 0 once it has been emptied.
  assign adBit    = (L > 0) ? adSh[LW-1] : 1'b0;
  assign ptBit    = (Y > 0) ? ptSh[YW-1] : 1'b0;
  assign encReady = readySeen | enc_readyxSI;

  assign ct_out      = ctR;
  assign tag_out     = tagR;
  assign pt_out      = ptR;
  assign dec_tag_out = decTagR;
  assign auth_ok     = authR;
  assign busy        = (state != IDLE);
  assign done        = doneR;
  assign timeout_err = timeoutErr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state decode and core-facing outputs.
  always_comb begin
    nextState          = state;
    timeoutHit         = 1'b0;
    keyxSO             = '0;
    noncexSO           = '0;
    associated_dataxSO = '0;
    plain_textxSO      = '0;
    r_64xSO            = '0;
    r_128xSO           = '0;
    r_ptxSO            = '0;
    enc_startxSO       = 1'b0;
    dec_startxSO       = 1'b0;
    case (state)
      IDLE: if (cmd_valid) nextState = LOAD;
      LOAD: begin
        r_128xSO           = rnd_in[20:18];
        r_ptxSO            = rnd_in[17:15];
        r_64xSO            = rnd_in[14:8];
        keyxSO             = {rnd_in[7:6], keySh[K-1]};
        associated_dataxSO = {rnd_in[5:4], adBit};
        plain_textxSO      = {rnd_in[3:2], ptBit};
        noncexSO           = {rnd_in[1:0], nonceSh[127]};
        if (cnt == K_LAST) nextState = WAIT_ENC;
      end
      WAIT_ENC: begin
        enc_startxSO = (cnt < START_LEN);
        // An early ready is remembered so the start pulse always runs full length.
        if (encReady && cnt >= START_LAST) nextState = GAP_ENC;
        else if (!encReady && cnt == TO_LAST) begin
          timeoutHit = 1'b1;
          nextState  = IDLE;
        end
      end
      GAP_ENC: if (cnt == GAP_LAST) nextState = READ_ENC;
      READ_ENC: if (cnt == K_LAST) nextState = decMode ? WAIT_DEC : DONE;
      WAIT_DEC: begin
        dec_startxSO = 1'b1;
        if (dec_readyxSI) nextState = GAP_DEC;
        else if (cnt == TO_LAST) begin
          timeoutHit = 1'b1;
          nextState  = IDLE;
        end
      end
      GAP_DEC: begin
        dec_startxSO = 1'b1;
        if (cnt == GAP_LAST) nextState = READ_DEC;
      end
      READ_DEC: begin
        dec_startxSO = 1'b1;
        if (cnt == K_LAST) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Counters, job capture/shift, result deserialisation and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      readySeen  <= 1'b0;
      decMode    <= 1'b0;
      doneR      <= 1'b0;
      timeoutErr <= 1'b0;
      keySh      <= '0;
      nonceSh    <= '0;
      adSh       <= '0;
      ptSh       <= '0;
      ctR        <= '0;
      ptR        <= '0;
      tagR       <= '0;
      decTagR    <= '0;
      authR      <= 1'b0;
    end else begin
      if (state == IDLE || nextState != state) cnt <= '0;
      else                                     cnt <= cnt + CW'(1);

      if (nextState != state)                         readySeen <= 1'b0;
      else if (state == WAIT_ENC && enc_readyxSI)     readySeen <= 1'b1;

      doneR <= timeoutHit || (nextState == DONE);
      if (timeoutHit) timeoutErr <= 1'b1;

      case (state)
        IDLE: if (cmd_valid) begin
          keySh      <= key_in;
          nonceSh    <= nonce_in;
          adSh       <= ad_in;
          ptSh       <= pt_in;
          decMode    <= cmd_dec;
          timeoutErr <= 1'b0;
        end
        LOAD: begin
          keySh   <= keySh << 1;
          nonceSh <= nonceSh << 1;
          adSh    <= adSh << 1;
          ptSh    <= ptSh << 1;
        end
        READ_ENC: begin
          for (int unsigned j = 0; j < 128; j++)
            if (cnt == CW'(j)) tagR[j] <= tagxSI;
          for (int unsigned j = 0; j < YW; j++)
            if (Y > 0 && cnt == CW'(j)) ctR[j] <= cipher_textxSI;
        end
        READ_DEC: begin
          for (int unsigned j = 0; j < 128; j++)
            if (cnt == CW'(j)) decTagR[j] <= dec_tagxSI;
          for (int unsigned j = 0; j < YW; j++)
            if (Y > 0 && cnt == CW'(j)) ptR[j] <= plain_textxSI;
          if (cnt == K_LAST) authR <= auth_xSI;
        end
        default: ;
      endcase
    end
  end

endmodule
